// File: rtl/cnt_arb_pkg.sv
// ============================================================================
// Module   : cnt_arb_pkg
// Purpose  : Shared state encoding, default width and arbitration helpers
//            for cnt_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_arb_pkg;

  localparam int unsigned W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Round-robin pick: on contention the requester not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_core.sv
// ============================================================================
// Module   : cnt_core
// Purpose  : W-bit up-counter with synchronous clear and count enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_core
  import cnt_arb_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cnt_arbiter.sv
// ============================================================================
// Module   : cnt_arbiter
// Purpose  : Two-requester round-robin arbiter granting a counted run of
//            len+1 cycles. Define CNT_ARB_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic [W-1:0] cnt,
  output logic [1:0]   done
`ifdef CNT_ARB_ABORT_EN
  ,
  input  logic         abort
`endif
);

  state_e       state_q;
  logic [1:0]   gnt_q;
  logic [1:0]   done_q;
  logic         busy_q;
  logic         last_q;
  logic         win_q;
  logic [W-1:0] len_q;
  logic [W-1:0] cnt_q;

  logic         win_d;
  logic         at_end;
  logic         abort_run;
  logic         cnt_clr;
  logic         cnt_en;

`ifdef CNT_ARB_ABORT_EN
  assign abort_run = abort && (state_q == RUN);
`else
  assign abort_run = 1'b0;
`endif

  assign win_d   = rr_pick(req, last_q);
  assign at_end  = (cnt_q == len_q);
  assign cnt_clr = (state_q == IDLE) && (req != 2'b00);
  // The counter stops on the terminal value so it never wraps.
  assign cnt_en  = (state_q == RUN) && !at_end && !abort_run;

  cnt_core #(
    .W(W)
  ) u_cnt_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            state_q <= RUN;
            win_q   <= win_d;
            gnt_q   <= onehot2(win_d);
            busy_q  <= 1'b1;
            len_q   <= win_d ? len1 : len0;
          end
        end
        RUN: begin
          if (abort_run) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= win_q;
          end else if (at_end) begin
            state_q <= DONE;
            gnt_q   <= 2'b00;
            done_q  <= onehot2(win_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          last_q  <= win_q;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cnt_arbiter.sv
// ============================================================================
// Module   : tb_cnt_arbiter
// Purpose  : Scoreboard bench for cnt_arbiter against a run-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_arbiter;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req   = 2'b00;
  logic [W-1:0] len0  = '0;
  logic [W-1:0] len1  = '0;
  logic         abort_i = 1'b0;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] cnt;
  logic [1:0]   done;

  cnt_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .busy  (busy),
    .cnt   (cnt),
    .done  (done)
`ifdef CNT_ARB_ABORT_EN
    ,
    .abort (abort_i)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic [W-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic         win;
    logic [W-1:0] len;
  } txn_t;

  exp_t cyc_q[$];
  txn_t txn_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // Reference model: a run is described by its grant edge e0 and length L.
  // Edges e0..e0+L are RUN, e0+L+1 is DONE, next grant earliest at e0+L+3.
  int           e;
  int           e0;
  int           nfree;
  bit           m_run;
  logic         m_last;
  logic         m_win;
  logic [W-1:0] m_len;
  logic [W-1:0] m_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic m_reset();
    e      = 0;
    nfree  = 0;
    m_run  = 1'b0;
    m_last = 1'b1;
    m_hold = '0;
    m_win  = 1'b0;
    m_len  = '0;
    e0     = 0;
    txn_q.delete();
    cyc_q.delete();
  endtask

  task automatic m_edge(input logic [1:0] r, input logic [W-1:0] l0,
                        input logic [W-1:0] l1, input logic ab);
    exp_t x;
    txn_t t;
    int   k;
    if (m_run && e >= e0 + int'(m_len) + 2) begin
      m_run  = 1'b0;
      m_hold = m_len;
    end
    if (m_run && ab && e > e0 && e <= e0 + int'(m_len) + 1) begin
      m_run  = 1'b0;
      m_hold = W'(e - 1 - e0);
      nfree  = e + 1;
      void'(txn_q.pop_back());
    end
    if (!m_run && e >= nfree && r != 2'b00) begin
      if (r == 2'b01)      m_win = 1'b0;
      else if (r == 2'b10) m_win = 1'b1;
      else                 m_win = ~m_last;
      m_last = m_win;
      m_len  = m_win ? l1 : l0;
      e0     = e;
      nfree  = e + int'(m_len) + 3;
      m_run  = 1'b1;
      t.win  = m_win;
      t.len  = m_len;
      txn_q.push_back(t);
    end
    x = '0;
    if (m_run) begin
      k = e - e0;
      x.busy = 1'b1;
      if (k <= int'(m_len)) begin
        x.gnt = m_win ? 2'b10 : 2'b01;
        x.cnt = W'(k);
      end else begin
        x.done = m_win ? 2'b10 : 2'b01;
        x.cnt  = m_len;
      end
    end else begin
      x.cnt = m_hold;
    end
    cyc_q.push_back(x);
    e++;
  endtask

  task automatic step(input logic [1:0] r, input logic [W-1:0] l0,
                      input logic [W-1:0] l1, input logic ab);
    logic ab_eff;
`ifdef CNT_ARB_ABORT_EN
    ab_eff = ab;
`else
    ab_eff = 1'b0;
`endif
    @(negedge clk);
    req = r; len0 = l0; len1 = l1; abort_i = ab;
    m_edge(r, l0, l1, ab_eff);
  endtask

  task automatic release_with(input logic [1:0] r, input logic [W-1:0] l0,
                              input logic [W-1:0] l1);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    req = r; len0 = l0; len1 = l1; abort_i = 1'b0;
    m_edge(r, l0, l1, 1'b0);
    mon_en = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_gnt",  gnt,  0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt",  cnt,  0);
    repeat (2) @(posedge clk);
  endtask

  exp_t mx;
  txn_t mt;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: actual=no expectation required=expectation at %0t", $time);
      end else begin
        mx = cyc_q.pop_front();
        chk("gnt",  gnt,  mx.gnt);
        chk("done", done, mx.done);
        chk("busy", busy, mx.busy);
        chk("cnt",  cnt,  mx.cnt);
        if (done != 2'b00) begin
          if (txn_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexp: actual=%0h required=no pulse at %0t", done, $time);
          end else begin
            mt = txn_q.pop_front();
            chk("done_who", done, (mt.win ? 2'b10 : 2'b01));
            chk("done_cnt", cnt,  mt.len);
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]   r;
    logic [W-1:0] l0;
    logic [W-1:0] l1;
    logic         ab;

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_gnt",  gnt,  0);
    chk("init_done", done, 0);
    chk("init_busy", busy, 0);
    chk("init_cnt",  cnt,  0);

    // Single request granted on the first edge out of reset.
    release_with(2'b01, 4'd3, 4'd0);
    repeat (3) step(2'b01, 4'd3, 4'd0, 1'b0);
    repeat (5) step(2'b00, 4'd3, 4'd0, 1'b0);

    // Contention from reset: 0, then 1, then 0 again.
    apply_reset();
    release_with(2'b11, 4'd1, 4'd2);
    repeat (12) step(2'b11, 4'd1, 4'd2, 1'b0);
    repeat (4) step(2'b00, 4'd1, 4'd2, 1'b0);

    // Length boundaries.
    step(2'b01, 4'd0, 4'd0, 1'b0);
    repeat (3) step(2'b00, 4'd0, 4'd0, 1'b0);
    step(2'b01, 4'd15, 4'd0, 1'b0);
    repeat (20) step(2'b00, 4'd15, 4'd0, 1'b0);

    // Reset while cnt=2 of a len=7 run.
    step(2'b01, 4'd7, 4'd0, 1'b0);
    repeat (2) step(2'b00, 4'd7, 4'd0, 1'b0);
    apply_reset();
    release_with(2'b00, 4'd0, 4'd0);
    repeat (12) step(2'b00, 4'd0, 4'd0, 1'b0);

    // Request drop and len change mid-run do not disturb the run.
    repeat (3) step(2'b01, 4'd5, 4'd0, 1'b0);
    repeat (8) step(2'b00, 4'd1, 4'd0, 1'b0);

    // Abort at cnt=2 of len=6 with requester 1 pending.
    step(2'b01, 4'd6, 4'd3, 1'b0);
    repeat (2) step(2'b11, 4'd6, 4'd3, 1'b0);
    step(2'b11, 4'd6, 4'd3, 1'b1);
    repeat (8) step(2'b11, 4'd6, 4'd3, 1'b0);
    repeat (10) step(2'b00, 4'd0, 4'd0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r  = 2'($urandom_range(0, 3));
      l0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 5));
      l1 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 5));
      ab = ($urandom_range(0, 19) == 0);
      step(r, l0, l1, ab);
    end
    repeat (25) step(2'b00, 4'd0, 4'd0, 1'b0);

    @(posedge clk);
    #2;
    chk("txn_left", txn_q.size(), 0);
    chk("cyc_left", cyc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cnt_arbiter.md
CNT_ARBITER -- requirements
Module: cnt_arbiter

Interface
REQ-001 SHALL have parameter: W, default 4, counter and length width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  2  level request per requester, index 0/1.
REQ-005 SHALL have port: len0  input  W  terminal count for requester 0, sampled at grant.
REQ-006 SHALL have port: len1  input  W  terminal count for requester 1, sampled at grant.
REQ-007 SHALL have port: gnt  output  2  one-hot grant, high for the whole run.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port: cnt  output  W  current shared counter value.
REQ-010 SHALL have port: done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port, only when CNT_ARB_ABORT_EN is defined: abort  input  1  cancel current run.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-013 IDLE: req != 0 at a rising edge -> RUN next cycle, gnt one-hot to winner, cnt = 0, len of winner latched.
REQ-014 SHALL arbitrate round-robin: when both request, the requester not most recently granted wins; after reset requester 0 has priority.
REQ-015 RUN: cnt increments by 1 per cycle; when cnt == latched len -> DONE next cycle.
REQ-016 Run length SHALL be len+1 cycles with gnt high (len=0 -> exactly one RUN cycle).
REQ-017 DONE: gnt = 0, done[winner] = 1 for exactly one cycle, cnt holds final value, priority pointer updates; -> IDLE next cycle.
REQ-018 Minimum request-to-request turnaround SHALL be one IDLE cycle after DONE; back-to-back grants never overlap.
REQ-019 cnt SHALL never wrap: max len = 2^W-1 terminates at cnt = 2^W-1.
REQ-020 req deassertion during RUN SHALL be ignored; run completes and done still pulses.
REQ-021 len0/len1 changes after grant SHALL NOT affect the current run.
REQ-022 In IDLE cnt SHALL hold last value; gnt, done, busy = 0.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, gnt = 0, done = 0, busy = 0, cnt = 0, priority to requester 0, including mid-run.
REQ-024 First grant SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-025 With CNT_ARB_ABORT_EN defined: abort high in RUN -> IDLE next cycle, gnt = 0, no done pulse, priority pointer still updates; abort ignored in IDLE/DONE.
REQ-026 Without CNT_ARB_ABORT_EN: no abort port, no abort logic; every run ends via DONE.

Structure
REQ-027 SHALL place FSM state encodings (IDLE, RUN, DONE) and default W in shared package cnt_arb_pkg.
REQ-028 SHALL instantiate one sub-module cnt_core: W-bit counter with synchronous clear and enable, async active-low reset.

Verification
REQ-029 Single req: req=01, len0=3 -> gnt=01 for 4 cycles, cnt 0,1,2,3, then done=01 one cycle, gnt=00.
REQ-030 Contention: req=11 from reset, len0=1, len1=2 -> requester 0 served first, then requester 1 (gnt=10 for 3 cycles); next contention grants 0 again.
REQ-031 Boundaries: len0=0 -> one RUN cycle, cnt=0, done next cycle; len0=15 (W=4) -> 16 RUN cycles ending at cnt=15, no wrap.
REQ-032 Reset mid-run: rst_n low at cnt=2 of len=7 -> gnt, done, busy, cnt all 0 immediately, no done pulse afterwards.
REQ-033 Stability: drop req and change len0 from 5 to 1 at cnt=2 -> run still ends at cnt=5 with done pulse.
REQ-034 CNT_ARB_ABORT_EN: abort at cnt=2 of len=6 -> IDLE next cycle, done never pulses, pending other requester granted next.
